// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
// Optional andi support is selected by MULTICYCLE_ANDI_EN.
package multicycle_control_pkg;

    localparam int OP_W = 6;
    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMRD    = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWR    = 4'd6,
        S_RTYPE_EX = 4'd7,
        S_RTYPE_WB = 4'd8,
        S_BEQ_EX   = 4'd9,
        S_ADDI_EX  = 4'd10,
        S_ADDI_WB  = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd13,
        S_ANDI_EX  = 4'd14,
        S_ANDI_WB  = 4'd15
    } state_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU = 2'b00;
    localparam logic [1:0] PCSRC_OUT = 2'b01;
    localparam logic [1:0] PCSRC_JMP = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    function automatic logic is_mem_op(input logic [OP_W-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the main FSM (master) and the multicycle datapath.
// The andi extension (MULTICYCLE_ANDI_EN) does not change this bundle.
interface multicycle_control_if;
    import multicycle_control_pkg::*;

    logic [OP_W-1:0] opcode;
    logic            mem_ready;
    logic            pc_write;
    logic            pc_write_cond;
    logic            i_or_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            mem_to_reg;
    logic            reg_dst;
    logic            reg_write;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      pc_source;
    logic [1:0]      alu_op;
    logic            halted;
    logic [ST_W-1:0] state_o;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
        output ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
        output alu_src_b, pc_source, alu_op, halted, state_o
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
        input  ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
        input  alu_src_b, pc_source, alu_op, halted, state_o
    );

endinterface

// File: rtl/mc_output_decode.sv
// State-to-strobe map of the multicycle control FSM (Moore, FETCH Mealy-qualified).
// ANDI_EX/ANDI_WB decode only when MULTICYCLE_ANDI_EN is defined.
module mc_output_decode
    import multicycle_control_pkg::*;
(
    input  state_t state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_4;
                // IR and PC only latch once the fetch actually completes
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            S_DECODE: ctrl_o.alu_src_b = SRCB_IMM2;
            S_MEMADR, S_ADDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.mem_write = 1'b1;
                ctrl_o.i_or_d    = 1'b1;
            end
            S_RTYPE_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_RTYPE_WB: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.reg_dst   = 1'b1;
            end
            S_BEQ_EX: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_OUT;
            end
            S_ADDI_WB: ctrl_o.reg_write = 1'b1;
            S_JUMP: begin
                ctrl_o.pc_write  = 1'b1;
                ctrl_o.pc_source = PCSRC_JMP;
            end
            S_HALT: ctrl_o.halted = 1'b1;
`ifdef MULTICYCLE_ANDI_EN
            S_ANDI_EX: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_AND;
            end
            S_ANDI_WB: ctrl_o.reg_write = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath.
// Define MULTICYCLE_ANDI_EN to execute andi instead of trapping on it.
module multicycle_control
    import multicycle_control_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    multicycle_control_if.master bus
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    bus.opcode == OP_RTYPE:  state_d = S_RTYPE_EX;
                    is_mem_op(bus.opcode):   state_d = S_MEMADR;
                    bus.opcode == OP_BEQ:    state_d = S_BEQ_EX;
                    bus.opcode == OP_ADDI:   state_d = S_ADDI_EX;
                    bus.opcode == OP_J:      state_d = S_JUMP;
`ifdef MULTICYCLE_ANDI_EN
                    bus.opcode == OP_ANDI:   state_d = S_ANDI_EX;
`endif
                    default:                 state_d = S_HALT;
                endcase
            end
            S_MEMADR:
                state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:    if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWR:    if (bus.mem_ready) state_d = S_FETCH;
            S_RTYPE_EX: state_d = S_RTYPE_WB;
            S_RTYPE_WB: state_d = S_FETCH;
            S_BEQ_EX:   state_d = S_FETCH;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_ADDI_WB:  state_d = S_FETCH;
            S_JUMP:     state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
`ifdef MULTICYCLE_ANDI_EN
            S_ANDI_EX:  state_d = S_ANDI_WB;
            S_ANDI_WB:  state_d = S_FETCH;
`endif
            default:    state_d = S_IDLE;
        endcase
    end

    mc_output_decode u_dec (
        .state_i     (state_q),
        .mem_ready_i (bus.mem_ready),
        .ctrl_o      (ctrl)
    );

    assign bus.pc_write      = ctrl.pc_write;
    assign bus.pc_write_cond = ctrl.pc_write_cond;
    assign bus.i_or_d        = ctrl.i_or_d;
    assign bus.mem_read      = ctrl.mem_read;
    assign bus.mem_write     = ctrl.mem_write;
    assign bus.ir_write      = ctrl.ir_write;
    assign bus.mem_to_reg    = ctrl.mem_to_reg;
    assign bus.reg_dst       = ctrl.reg_dst;
    assign bus.reg_write     = ctrl.reg_write;
    assign bus.alu_src_a     = ctrl.alu_src_a;
    assign bus.alu_src_b     = ctrl.alu_src_b;
    assign bus.pc_source     = ctrl.pc_source;
    assign bus.alu_op        = ctrl.alu_op;
    assign bus.halted        = ctrl.halted;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed vector table, async-reset cases,
// and random instruction streams against a per-instruction state-sequence model.
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int n_checks = 0;
    int n_fail = 0;

    // {pc_write,pc_write_cond,i_or_d,mem_read,mem_write,ir_write,
    //  mem_to_reg,reg_dst,reg_write,alu_src_a,alu_src_b,pc_source,alu_op,halted}
    localparam logic [16:0] V_IDLE = 17'b0;
    localparam logic [16:0] V_FETCH = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                       4'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] V_FST = {3'b0, 1'b1, 6'b0, 2'b01, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] V_DEC = {10'b0, 2'b11, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] V_MADR = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] V_MRD = {2'b0, 1'b1, 1'b1, 6'b0, 7'b0};
    localparam logic [16:0] V_MWB = {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 7'b0};
    localparam logic [16:0] V_MWR = {2'b0, 1'b1, 1'b0, 1'b1, 5'b0, 7'b0};
    localparam logic [16:0] V_REX = {9'b0, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0};
    localparam logic [16:0] V_RWB = {7'b0, 1'b1, 1'b1, 1'b0, 7'b0};
    localparam logic [16:0] V_BEQ = {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
    localparam logic [16:0] V_AEX = {9'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
    localparam logic [16:0] V_AWB = {8'b0, 1'b1, 1'b0, 7'b0};
    localparam logic [16:0] V_J = {1'b1, 9'b0, 2'b00, 2'b10, 2'b00, 1'b0};
    localparam logic [16:0] V_HALT = {16'b0, 1'b1};
    localparam logic [16:0] V_NEX = {9'b0, 1'b1, 2'b10, 2'b00, 2'b11, 1'b0};

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic [3:0]  st;
        logic [16:0] v;
    } vec_t;

    vec_t vt[$];

    function automatic logic [16:0] outs();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                bus.alu_op, bus.halted};
    endfunction

    task automatic chk(input string nm, input logic [3:0] est, input logic [16:0] ev);
        n_checks++;
        if (bus.state_o !== est || outs() !== ev) begin
            n_fail++;
            $display("FAIL %s: state %0d outs %b, required state %0d outs %b",
                     nm, bus.state_o, outs(), est, ev);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy,
                       input logic [3:0] st, input logic [16:0] v);
        vec_t e;
        e.op = op; e.rdy = rdy; e.st = st; e.v = v;
        vt.push_back(e);
    endtask

    task automatic new_instr(output logic [5:0] op, output int seq[$]);
        int k;
`ifdef MULTICYCLE_ANDI_EN
        k = int'($urandom_range(0, 6));
`else
        k = int'($urandom_range(0, 5));
`endif
        case (k)
            0: begin op = OP_RTYPE; seq = '{1, 2, 7, 8}; end
            1: begin op = OP_LW;    seq = '{1, 2, 3, 4, 5}; end
            2: begin op = OP_SW;    seq = '{1, 2, 3, 6}; end
            3: begin op = OP_BEQ;   seq = '{1, 2, 9}; end
            4: begin op = OP_ADDI;  seq = '{1, 2, 10, 11}; end
            5: begin op = OP_J;     seq = '{1, 2, 12}; end
            default: begin op = OP_ANDI; seq = '{1, 2, 14, 15}; end
        endcase
    endtask

    task automatic run_random(input int n_instr);
        int seq[$];
        int pos;
        int st;
        int done;
        logic [5:0] op;
        logic rdy;
        logic [5:0] act;
        logic [5:0] exp;
        @(negedge clk);
        rst_n = 1'b1;
        bus.mem_ready = 1'($urandom_range(0, 1));
        #1 chk("rnd_idle", 4'd0, V_IDLE);
        new_instr(op, seq);
        bus.opcode = op;
        pos = 0;
        done = 0;
        while (done < n_instr) begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            bus.mem_ready = rdy;
            #1;
            st = seq[pos];
            exp = {4'(st) == bus.state_o ? 1'b1 : 1'b0,
                   st == 1 || st == 4,
                   st == 6,
                   st == 1 && rdy,
                   (st == 1 && rdy) || st == 12,
                   st == 5 || st == 8 || st == 11 || st == 15};
            act = {1'b1, bus.mem_read, bus.mem_write, bus.ir_write,
                   bus.pc_write, bus.reg_write};
            n_checks++;
            if (act !== exp || bus.state_o !== 4'(st) || bus.halted !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd op=%b pos=%0d: state %0d strobes %b, required state %0d strobes %b",
                         op, pos, bus.state_o, act[4:0], st, exp[4:0]);
            end
            if (!(st == 1 || st == 4 || st == 6) || rdy) pos++;
            if (pos == seq.size()) begin
                done++;
                new_instr(op, seq);
                bus.opcode = op;
                pos = 0;
            end
        end
    endtask

    initial begin
        bus.opcode = OP_RTYPE;
        bus.mem_ready = 1'b1;

        add(OP_RTYPE, 1, 0, V_IDLE);
        add(OP_RTYPE, 1, 1, V_FETCH);
        add(OP_RTYPE, 0, 2, V_DEC);
        add(OP_RTYPE, 0, 7, V_REX);
        add(OP_RTYPE, 1, 8, V_RWB);
        add(OP_LW, 0, 1, V_FST);
        add(OP_LW, 0, 1, V_FST);
        add(OP_LW, 1, 1, V_FETCH);
        add(OP_LW, 0, 2, V_DEC);
        add(OP_LW, 0, 3, V_MADR);
        add(OP_LW, 0, 4, V_MRD);
        add(OP_LW, 0, 4, V_MRD);
        add(OP_LW, 0, 4, V_MRD);
        add(OP_LW, 1, 4, V_MRD);
        add(OP_LW, 0, 5, V_MWB);
        add(OP_SW, 1, 1, V_FETCH);
        add(OP_SW, 1, 2, V_DEC);
        add(OP_SW, 1, 3, V_MADR);
        add(OP_SW, 1, 6, V_MWR);
        add(OP_BEQ, 1, 1, V_FETCH);
        add(OP_BEQ, 0, 2, V_DEC);
        add(OP_BEQ, 0, 9, V_BEQ);
        add(OP_J, 1, 1, V_FETCH);
        add(OP_J, 1, 2, V_DEC);
        add(OP_J, 1, 12, V_J);
        add(OP_ADDI, 1, 1, V_FETCH);
        add(OP_ADDI, 1, 2, V_DEC);
        add(OP_ADDI, 1, 10, V_AEX);
        add(OP_ADDI, 1, 11, V_AWB);
        add(OP_ANDI, 1, 1, V_FETCH);
        add(OP_ANDI, 1, 2, V_DEC);
`ifdef MULTICYCLE_ANDI_EN
        add(OP_ANDI, 1, 14, V_NEX);
        add(OP_ANDI, 1, 15, V_AWB);
        add(6'h3f, 1, 1, V_FETCH);
        add(6'h3f, 1, 2, V_DEC);
`endif
        add(OP_RTYPE, 0, 13, V_HALT);
        add(OP_RTYPE, 1, 13, V_HALT);
        add(OP_LW, 0, 13, V_HALT);
        add(OP_SW, 1, 13, V_HALT);

        #1;
        @(negedge clk);
        chk("reset", 4'd0, V_IDLE);

        for (int i = 0; i < vt.size(); i++) begin
            @(negedge clk);
            bus.opcode = vt[i].op;
            bus.mem_ready = vt[i].rdy;
            if (i == 0) rst_n = 1'b1;
            #1 chk($sformatf("vec%0d", i), vt[i].st, vt[i].v);
        end

        // asynchronous reset out of HALT
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("halt_rst", 4'd0, V_IDLE);

        // sw stalled in MEMWR, then reset mid-write
        @(negedge clk);
        rst_n = 1'b1;
        bus.opcode = OP_SW;
        bus.mem_ready = 1'b1;
        #1 chk("sw_idle", 4'd0, V_IDLE);
        @(negedge clk);
        #1 chk("sw_fetch", 4'd1, V_FETCH);
        @(negedge clk);
        #1 chk("sw_dec", 4'd2, V_DEC);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1 chk("sw_madr", 4'd3, V_MADR);
        @(negedge clk);
        #1 chk("sw_wr_stall1", 4'd6, V_MWR);
        @(negedge clk);
        #1 chk("sw_wr_stall2", 4'd6, V_MWR);
        #2 rst_n = 1'b0;
        #1 chk("memwr_rst", 4'd0, V_IDLE);

        run_random(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
